// File: rtl/hash_loader_pkg.sv
// Shared definitions for the Ascon hash message loader.
// State encoding, default byte width and the bytes-per-message helper.
package hash_loader_pkg;

   localparam logic [2:0] COLLECT   = 3'd0;
   localparam logic [2:0] LAUNCH    = 3'd1;
   localparam logic [2:0] WAIT_HASH = 3'd2;
   localparam logic [2:0] HOLD      = 3'd3;
   localparam logic [2:0] RELEASE   = 3'd4;

   localparam int BW_DEF = 8;

   function automatic int calc_nb(input int y, input int bw);
      return (y + bw - 1) / bw;
   endfunction

endpackage

// File: rtl/msg_byte_packer.sv
// Byte counter and MSB-first packer for the hash message register.
// Clears the whole register when byte 0 of a new message arrives.
module msg_byte_packer
   import hash_loader_pkg::*;
#(
   parameter  int y  = 40,
   parameter  int BW = BW_DEF,
   localparam int NB = calc_nb(y, BW),
   localparam int CW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          acc,
   input  logic          eom,
   input  logic [BW-1:0] in_data,
   output logic [y-1:0]  message,
   output logic [CW-1:0] cnt
);

   // Packing space is whole bytes; the top y bits form the message,
   // so the low bits of a partial final byte simply fall off.
   localparam int W = NB * BW;

   logic [W-1:0]  wide_q, wide_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Next packing register and byte index on an accepted byte
   always_comb begin
      wide_d = wide_q;
      cnt_d  = cnt_q;
      if (acc) begin
         if (cnt_q == '0) wide_d = '0;
         for (int k = 0; k < NB; k++) begin
            if (cnt_q == CW'(k)) wide_d[W-1-k*BW -: BW] = in_data;
         end
         cnt_d = eom ? '0 : cnt_q + 1'b1;
      end
   end

   // Packing register and byte counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wide_q <= '0;
         cnt_q  <= '0;
      end else begin
         wide_q <= wide_d;
         cnt_q  <= cnt_d;
      end
   end

   assign message = wide_q[W-1 -: y];
   assign cnt     = cnt_q;

endmodule

// File: rtl/hash_msg_loader.sv
// Byte-stream front-end and start sequencer for the Ascon hash core.
// LOADER_LATENCY_CNT_EN adds the hash_cycles latency counter output.
module hash_msg_loader
   import hash_loader_pkg::*;
#(
   parameter int y  = 40,
   parameter int BW = BW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [BW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [y-1:0]  message,
   output logic          start,
   input  logic          hash_ready,
   output logic          digest_valid,
   input  logic          digest_ack,
   output logic          len_err,
`ifdef LOADER_LATENCY_CNT_EN
   output logic [15:0]   hash_cycles,
`endif
   output logic          busy
);

   localparam int NB = calc_nb(y, BW);
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   logic [2:0]    state_q, state_d;
   logic          len_err_q, len_err_d;
   logic [CW-1:0] cnt;
   logic          acc, at_last, eom;

   assign acc     = in_valid & in_ready;
   assign at_last = (cnt == CW'(NB - 1));
   assign eom     = in_last | at_last;

   msg_byte_packer #(
      .y  (y),
      .BW (BW)
   ) u_packer (
      .clk     (clk),
      .rst     (rst),
      .acc     (acc),
      .eom     (eom),
      .in_data (in_data),
      .message (message),
      .cnt     (cnt)
   );

   // Loader sequencing: collect, launch, wait, hold digest, release
   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT:   if (acc && eom)  state_d = LAUNCH;
         LAUNCH:                     state_d = WAIT_HASH;
         WAIT_HASH: if (hash_ready)  state_d = HOLD;
         HOLD:      if (digest_ack)  state_d = RELEASE;
         RELEASE:                    state_d = COLLECT;
         default:                    state_d = COLLECT;
      endcase
   end

   // Length error: cleared by byte 0, set by early or missing in_last
   always_comb begin
      len_err_d = len_err_q;
      if (acc) begin
         if (cnt == '0) len_err_d = 1'b0;
         if (in_last != at_last) len_err_d = 1'b1;
      end
   end

   // FSM and error flag registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= COLLECT;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_err_q <= len_err_d;
      end
   end

`ifdef LOADER_LATENCY_CNT_EN
   logic [15:0] cyc_q, cyc_d;

   // Saturating count of WAIT_HASH cycles, frozen outside the wait
   always_comb begin
      cyc_d = cyc_q;
      if (state_q == LAUNCH) cyc_d = '0;
      else if (state_q == WAIT_HASH && cyc_q != 16'hFFFF)
         cyc_d = cyc_q + 16'd1;
   end

   // Latency counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cyc_q <= '0;
      else      cyc_q <= cyc_d;
   end

   assign hash_cycles = cyc_q;
`endif

   assign in_ready     = rst & (state_q == COLLECT);
   assign start        = (state_q == LAUNCH) | (state_q == RELEASE);
   assign digest_valid = (state_q == HOLD);
   assign busy         = (state_q != COLLECT);
   assign len_err      = len_err_q;

endmodule

// File: doc/hash_msg_loader.md
Name: hash_msg_loader

Overview:
- Upstream front-end for the Ascon hash core.
- Accepts the message as a byte stream with a valid/ready handshake and packs it MSB-first into a y-bit message register.
- Sequences the core's start line: one pulse to launch, one pulse to return the core to idle after the digest is consumed.
- Holds the message stable for the whole hash, and gives the downstream consumer a digest_valid/digest_ack handshake.

Parameters:
- y, 40, message width in bits; must match the core's y.
- BW, 8, input byte width.
- NB, ceil(y/BW) (derived, not overridable), bytes per message.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_data  in  BW  message byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks final byte of message.
- in_ready  out  1  loader can accept a byte.
- message  out  y  packed message, to core message input.
- start  out  1  core start, single-cycle pulses.
- hash_ready  in  1  core ready output.
- digest_valid  out  1  core digest is valid for capture.
- digest_ack  in  1  consumer has captured the digest.
- len_err  out  1  last message had a length mismatch.
- busy  out  1  high in every state except COLLECT.

Behaviour:
- Reset (rst=0, async):
  - state=COLLECT; byte counter=0; message=0.
  - start=0, digest_valid=0, len_err=0, busy=0.
  - in_ready=1 once rst is deasserted.
  - Reset mid-hash simply aborts; the core shares rst and returns to idle.
- A byte is accepted on any rising edge with in_valid & in_ready.
- Packing:
  - Byte k (0-based) is written to message[y-1-k*BW -: BW].
  - If y%BW != 0, the final byte contributes only in_data[BW-1 -: y%BW]; its low bits are dropped.
  - Bytes not yet written hold 0.
  - On the first byte of a message, the whole message register is cleared before byte 0 is written, and len_err is cleared.
- COLLECT: in_ready=1. Go to LAUNCH when a byte is accepted with in_last=1 or with counter==NB-1, whichever comes first.
  - len_err is set if in_last arrives with counter<NB-1 (short message; missing bytes stay 0).
  - len_err is also set if byte NB-1 arrives without in_last; the next byte then starts a new message.
- LAUNCH (1 cycle): start=1, in_ready=0. Next state WAIT_HASH.
- WAIT_HASH: in_ready=0, start=0. Go to HOLD when hash_ready=1.
- HOLD: digest_valid=1. When digest_ack=1, go to RELEASE.
  - digest_ack sampled in the same cycle digest_valid first rises is honoured.
- RELEASE (1 cycle): start=1 (returns core from DONE to IDLE), digest_valid=0. Next state COLLECT.
- Latency: start rises in the cycle after the accepting edge of the final byte.
- message is frozen from LAUNCH through RELEASE; it changes only on accepted bytes.
- digest_ack outside HOLD is ignored. in_valid while in_ready=0 is held off, not dropped.
- All outputs are registered or decoded from registered state; no combinational path from in_valid to in_ready.

Optional Feature:
- Macro LOADER_LATENCY_CNT_EN.
- Enabled:
  - Extra output hash_cycles[15:0].
  - A counter clears in LAUNCH and increments every WAIT_HASH cycle, saturating at 16'hFFFF.
  - The value is frozen at entry to HOLD and holds until the next LAUNCH.
  - Reset value 0.
- Disabled: no port, no counter logic.

Decomposition:
- Package hash_loader_pkg holds:
  - state encoding (COLLECT, LAUNCH, WAIT_HASH, HOLD, RELEASE), 3 bits;
  - BW default;
  - a function computing NB from y and BW.
- One natural sub-module, msg_byte_packer: byte counter, MSB-first packing and clear-on-first-byte.
- The FSM stays in the top module.

Test Plan:
- y=40, send bytes 01,02,03,04,05 with last on 05 → message=40'h0102030405; start high exactly one cycle, the cycle after 05 is accepted; len_err=0.
- Continue: model asserts hash_ready 30 cycles later → digest_valid=1. Pulse digest_ack → one start pulse, then in_ready=1 in the following cycle.
- Short message AA,BB with last on BB → message=40'hAABB000000, len_err=1, launch proceeds. Next message's first byte clears len_err.
- y=36, bytes 11,22,33,44,5F → message=36'h112233445; low nibble F dropped.
- Hold in_valid=1 during WAIT_HASH → in_ready=0, no byte accepted, message unchanged. Assert rst mid-HOLD → all outputs 0 immediately (async), state COLLECT.
- With LOADER_LATENCY_CNT_EN and a model that raises hash_ready after 25 WAIT_HASH cycles → hash_cycles=25, stable until next launch.
